imem_responder: RTL and testbench

- Multi-cycle instruction-memory responder; the memory side of the fetch read interface.
- Accepts one word-read request at a time from the fetch stage and returns a 16-bit instruction after a fixed LATENCY.
- Drives stall back to fetch while a read is in flight.
- Provides a load/write port for program initialisation by the bench or loader.

---
 rtl/imem_responder.sv | 154 +++++++++++++++
 tb/tb_imem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder
// --------------
// Memory side of the fetch read interface. One word read is accepted at a
// time. The 16-bit instruction comes back LATENCY cycles after acceptance.
// stall is held high while the read is in flight. A separate loader port
// writes words into the array at any time.
//
// Handshake: a request is taken on a rising edge when req=1 and flush=0 and
// the responder is not busy (state IDLE or DONE). addr is captured on that
// edge. The result is valid for exactly the one cycle in which done=1.
// Requests seen while busy are dropped, not queued.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   req       in   read request from fetch
//   addr      in   byte address of requested instruction
//   flush     in   cancel any pending read; a req in the same cycle is dropped
//   wr_en     in   loader write enable
//   wr_addr   in   loader byte address (bit 0 ignored)
//   wr_data   in   loader write data
//   data_out  out  returned instruction, valid when done=1
//   done      out  one-cycle result-valid pulse
//   err       out  misaligned-address flag, qualified by done
//   stall     out  busy; fetch must hold its PC
module imem_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic [15:0]       data_out,
    output logic              done,
    output logic              err,
    output logic              stall
);

    localparam int DEPTH = 1 << (ADDR_W - 1);
    // BUSY is entered with LATENCY-2 so that DONE follows LATENCY-1 edges
    // after the accepting edge.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              stall_q;

    logic              enter_done;
    logic [ADDR_W-1:0] rd_addr;

    logic [15:0]       mem [DEPTH];

    // Byte-lane bit of the loader address is intentionally unused.
    logic unused_wr_lsb;
    assign unused_wr_lsb = wr_addr[0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        enter_done = 1'b0;
        rd_addr    = addr_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (req) begin
                        addr_d = addr;
                        // With single-cycle latency the read happens on the
                        // accepting edge, so use the live address.
                        rd_addr = addr;
                        if (LATENCY == 1) begin
                            state_d    = DONE;
                            enter_done = 1'b1;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        // Array is sampled before this edge's write lands, so a same-edge
        // write to the word is not seen.
        if (enter_done) begin
            err_d  = rd_addr[0];
            data_d = rd_addr[0] ? 16'h0000 : mem[rd_addr[ADDR_W-1:1]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 16'h0000;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            stall_q <= (state_d == BUSY);
        end
    end

    // Loader writes are independent of the read FSM; the array has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[ADDR_W-1:1]] <= wr_data;
        end
    end

    assign data_out = data_q;
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign stall    = stall_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    // ---------------- clock / reset / stimulus signals ----------------
    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        req     = 1'b0;
    logic [15:0] addr    = 16'h0000;
    logic        flush   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [15:0] wr_addr = 16'h0000;
    logic [15:0] wr_data = 16'h0000;

    logic [15:0] dout4, dout1;
    logic        done4, done1, err4, err1, stall4, stall1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_W(16), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .data_out(dout4), .done(done4), .err(err4), .stall(stall4)
    );

    imem_responder #(.ADDR_W(16), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .data_out(dout1), .done(done1), .err(err1), .stall(stall1)
    );

    // ---------------- behavioural model ----------------
    // Each instance: a read is "pending" with k edges left until its result
    // appears. Index 0 models LATENCY=4, index 1 models LATENCY=1.
    int          lat    [2] = '{4, 1};
    bit          pend   [2] = '{default: 1'b0};
    int          k      [2] = '{default: 0};
    logic [15:0] la     [2] = '{default: 16'h0};
    logic        ed     [2] = '{default: 1'b0};
    logic        eerr   [2] = '{default: 1'b0};
    logic [15:0] edata  [2] = '{default: 16'h0};
    logic [15:0] mm     [64];
    logic [16:0] exp_q  [$];

    function automatic void finish_read(int i);
        logic [15:0] a;
        a = la[i];
        ed[i]    = 1'b1;
        eerr[i]  = a[0];
        edata[i] = a[0] ? 16'h0000 : mm[a[6:1]];
        if (i == 0) exp_q.push_back({eerr[0], edata[0]});
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] = 1'b0; k[i] = 0; ed[i] = 1'b0;
                eerr[i] = 1'b0; edata[i] = 16'h0000;
            end
            exp_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                ed[i] = 1'b0;
                if (flush) begin
                    pend[i] = 1'b0;
                end else if (pend[i]) begin
                    k[i] = k[i] - 1;
                    if (k[i] == 0) begin
                        pend[i] = 1'b0;
                        finish_read(i);
                    end
                end else if (req) begin
                    la[i] = addr;
                    k[i]  = lat[i] - 1;
                    if (k[i] == 0) finish_read(i);
                    else pend[i] = 1'b1;
                end
            end
            if (wr_en) mm[wr_addr[6:1]] = wr_data;
        end
    end

    // ---------------- checking ----------------
    task automatic check(string name, logic [16:0] act, logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        check("l4_done",  17'(done4),  17'(ed[0]));
        check("l4_stall", 17'(stall4), 17'(pend[0]));
        check("l4_err",   17'(err4),   17'(eerr[0]));
        check("l4_data",  17'(dout4),  17'(edata[0]));
        check("l1_done",  17'(done1),  17'(ed[1]));
        check("l1_stall", 17'(stall1), 17'(pend[1]));
        check("l1_err",   17'(err1),   17'(eerr[1]));
        check("l1_data",  17'(dout1),  17'(edata[1]));
        check("l1_stall_never", 17'(stall1), 17'h0);
        if (done4 === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL l4_sb: got unexpected done, expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("l4_sb", {err4, dout4}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_word(logic [15:0] a, logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Hand-computed expectations for the LATENCY=4 instance in the current cycle.
    task automatic expect_cycle(string tag, logic e_done, logic e_stall,
                                logic [15:0] e_data, logic e_err);
        @(negedge clk);
        check({tag, "_done"},  17'(done4),  17'(e_done));
        check({tag, "_stall"}, 17'(stall4), 17'(e_stall));
        if (e_done) begin
            check({tag, "_data"}, 17'(dout4), 17'(e_data));
            check({tag, "_err"},  17'(err4),  17'(e_err));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset held with req active.
        #1 rst = 1'b0;
        req = 1'b1; addr = 16'h0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_done4",  17'(done4),  17'h0);
            check("rst_stall4", 17'(stall4), 17'h0);
            check("rst_data4",  17'(dout4),  17'h0);
            check("rst_done1",  17'(done1),  17'h0);
            tick();
        end
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_done",  17'(done4),  17'h0);
        check("post_rst_stall", 17'(stall4), 17'h0);
        tick();

        // Preload the test region.
        for (int w = 0; w < 64; w++) wr_word(16'(w * 2), 16'($urandom));

        // Basic read; addr changes after acceptance must be ignored.
        wr_word(16'h0010, 16'hA5C3);
        req = 1'b1; addr = 16'h0010;
        tick();
        req = 1'b0; addr = 16'h0002;
        for (int c = 1; c <= 5; c++) begin
            expect_cycle("basic", c == 4, c <= 3, 16'hA5C3, 1'b0);
            tick();
        end

        // Back-to-back; req held through BUSY is ignored, taken in DONE.
        wr_word(16'h0000, 16'h1111);
        wr_word(16'h0002, 16'h2222);
        req = 1'b1; addr = 16'h0000;
        tick();
        addr = 16'h0002;
        for (int c = 1; c <= 9; c++) begin
            if (c == 8) req = 1'b0;
            expect_cycle("b2b", (c == 4) || (c == 8), (c <= 3) || (c >= 5 && c <= 7),
                         (c == 4) ? 16'h1111 : 16'h2222, 1'b0);
            tick();
        end

        // Flush during BUSY cancels the read.
        req = 1'b1; addr = 16'h0010;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) flush = 1'b1;
            if (c == 3) flush = 1'b0;
            expect_cycle("flush", 1'b0, c <= 2, 16'h0000, 1'b0);
            tick();
        end
        req = 1'b1; addr = 16'h0002;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            expect_cycle("post_flush", c == 4, c <= 3, 16'h2222, 1'b0);
            tick();
        end

        // Flush (with req) in the DONE cycle keeps that done, drops the req.
        req = 1'b1; addr = 16'h0010;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) begin flush = 1'b1; req = 1'b1; end
            if (c == 5) begin flush = 1'b0; req = 1'b0; end
            expect_cycle("flush_done", c == 4, c <= 3, 16'hA5C3, 1'b0);
            tick();
        end

        // Misaligned address.
        req = 1'b1; addr = 16'h0013;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            expect_cycle("misalign", c == 4, c <= 3, 16'h0000, 1'b1);
            tick();
        end

        // Same-edge write race: LATENCY=1 returns old data; LATENCY=4 sees new.
        wr_word(16'h0020, 16'hBEEF);
        req = 1'b1; addr = 16'h0020;
        wr_en = 1'b1; wr_addr = 16'h0020; wr_data = 16'h1234;
        tick();
        req = 1'b0; wr_en = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            expect_cycle("race_l4", c == 4, c <= 3, 16'h1234, 1'b0);
            if (c == 1) begin
                check("race_l1_done", 17'(done1), 17'h1);
                check("race_l1_data", 17'(dout1), 17'hBEEF);
            end
            tick();
        end
        req = 1'b1; addr = 16'h0020;
        tick();
        req = 1'b0;
        @(negedge clk);
        check("l1_after_race_done", 17'(done1), 17'h1);
        check("l1_after_race_data", 17'(dout1), 17'h1234);
        tick();

        // Randomised traffic, including occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            req     = ($urandom_range(0, 99) < 50);
            addr    = 16'($urandom_range(0, 127));
            flush   = ($urandom_range(0, 99) < 8);
            wr_en   = ($urandom_range(0, 99) < 20);
            wr_addr = 16'($urandom_range(0, 127));
            wr_data = 16'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                wr_en = 1'b0;
                rst   = 1'b0;
            end else begin
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b1; req = 1'b0; flush = 1'b0; wr_en = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("sb_drained", 17'(exp_q.size()), 17'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
